berzerk_rom_loader: RTL and testbench

- Sits between the HPS download stream and the berzerk core.
- Decodes the ioctl byte stream into write strobes for the core's program ROM and speech ROM.
- Counts and checksums every accepted byte.
- Holds the core in reset until a complete, valid image has loaded, and reports done or error status for the OSD and LED.

---
 rtl/berzerk_rom_loader_pkg.sv | 19 +
 rtl/berzerk_rom_loader_region_dec.sv | 24 ++
 rtl/berzerk_rom_loader.sv | 161 ++++++++++++++++
 tb/tb_berzerk_rom_loader.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/berzerk_rom_loader_pkg.sv
// Shared types and constants for the berzerk ROM download path.
package berzerk_pkg;

  localparam int unsigned IOCTL_AW = 25;
  localparam int unsigned PRG_AW   = 14;
  localparam int unsigned SPK_AW   = 12;
  localparam int unsigned CNT_W    = 17;
  localparam int unsigned PRG_BASE = 0;
  localparam int unsigned SPK_BASE = 14336;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

endpackage

// File: rtl/berzerk_rom_loader_region_dec.sv
// Maps a download byte address onto the program ROM, the speech ROM or the
// out-of-image region, and gives the address relative to the region base.
module berzerk_dl_region_dec
  import berzerk_pkg::*;
#(
  parameter int unsigned PRG_SIZE = 14336,
  parameter int unsigned SPK_SIZE = 4096
) (
  input  logic [IOCTL_AW-1:0] addr_i,
  output logic                is_prg_o,
  output logic                is_spk_o,
  output logic                is_ovf_o,
  output logic [PRG_AW-1:0]   rel_addr_o
);

  always_comb begin
    is_prg_o   = addr_i < IOCTL_AW'(PRG_SIZE);
    is_spk_o   = !is_prg_o && (addr_i < IOCTL_AW'(PRG_SIZE + SPK_SIZE));
    is_ovf_o   = !is_prg_o && !is_spk_o;
    rel_addr_o = is_prg_o ? addr_i[PRG_AW-1:0]
                          : PRG_AW'(addr_i - IOCTL_AW'(PRG_SIZE));
  end

endmodule

// File: rtl/berzerk_rom_loader.sv
// Turns the HPS ioctl byte stream into program/speech ROM writes, tallies the
// image, and keeps the core in reset until a complete valid image is resident.
module berzerk_rom_loader
  import berzerk_pkg::*;
#(
  parameter int unsigned PRG_SIZE   = 14336,
  parameter int unsigned SPK_SIZE   = 4096,
  parameter int unsigned CHECK_EN   = 1,
  parameter logic [7:0]  EXPECT_SUM = 8'h00
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic                ioctl_download,
  input  logic                ioctl_wr,
  input  logic [IOCTL_AW-1:0] ioctl_addr,
  input  logic [7:0]          ioctl_dout,
  output logic [PRG_AW-1:0]   prg_addr,
  output logic [7:0]          prg_data,
  output logic                prg_we,
  output logic [SPK_AW-1:0]   spk_addr,
  output logic [7:0]          spk_data,
  output logic                spk_we,
  output logic                core_reset,
  output logic                load_done,
  output logic                load_err,
  output logic [CNT_W-1:0]    byte_count,
  output logic [7:0]          checksum
);

  loader_state_t state_q, state_d;
  logic dl_q, ovf_q, ovf_d;
  logic prg_we_q, prg_we_d, spk_we_q, spk_we_d;
  logic [PRG_AW-1:0] prg_addr_q, prg_addr_d;
  logic [SPK_AW-1:0] spk_addr_q, spk_addr_d;
  logic [7:0] prg_data_q, prg_data_d, spk_data_q, spk_data_d;
  logic [7:0] checksum_q, checksum_d;
  logic [CNT_W-1:0] byte_count_q, byte_count_d;
  logic core_reset_q, core_reset_d, load_done_q, load_done_d, load_err_q, load_err_d;

  logic rise, fall, accept, image_ok;
  logic is_prg, is_spk, is_ovf;
  logic [PRG_AW-1:0] rel_addr;

  berzerk_dl_region_dec #(
    .PRG_SIZE (PRG_SIZE),
    .SPK_SIZE (SPK_SIZE)
  ) u_region_dec (
    .addr_i     (ioctl_addr),
    .is_prg_o   (is_prg),
    .is_spk_o   (is_spk),
    .is_ovf_o   (is_ovf),
    .rel_addr_o (rel_addr)
  );

  // A rise always wins, so a strobe in the rise cycle never lands.
  assign rise     = ioctl_download & ~dl_q;
  assign fall     = dl_q & ~ioctl_download;
  assign accept   = (state_q == LOAD) && ioctl_wr && !rise;
  assign image_ok = (byte_count_q == CNT_W'(PRG_SIZE + SPK_SIZE)) && !ovf_q &&
                    ((CHECK_EN == 0) || (checksum_q == EXPECT_SUM));

  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (rise) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD:    if (fall) state_d = CHECK;
        CHECK:   state_d = image_ok ? DONE : ERR;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    prg_we_d     = 1'b0;
    spk_we_d     = 1'b0;
    prg_addr_d   = prg_addr_q;
    prg_data_d   = prg_data_q;
    spk_addr_d   = spk_addr_q;
    spk_data_d   = spk_data_q;
    byte_count_d = byte_count_q;
    checksum_d   = checksum_q;
    ovf_d        = ovf_q;
    if (rise) begin
      byte_count_d = '0;
      checksum_d   = '0;
      ovf_d        = 1'b0;
    end else if (accept) begin
      if (is_prg) begin
        prg_we_d   = 1'b1;
        prg_addr_d = rel_addr;
        prg_data_d = ioctl_dout;
      end else if (is_spk) begin
        spk_we_d   = 1'b1;
        spk_addr_d = rel_addr[SPK_AW-1:0];
        spk_data_d = ioctl_dout;
      end
      if (is_ovf) begin
        ovf_d = 1'b1;
      end else begin
        checksum_d = checksum_q + ioctl_dout;
        if (byte_count_q != '1) byte_count_d = byte_count_q + CNT_W'(1);
      end
    end
    // Status follows the next state so it changes on the same edge as the state.
    core_reset_d = (state_d != DONE);
    load_done_d  = (state_d == DONE);
    load_err_d   = (state_d == ERR);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q         <= 1'b0;
      ovf_q        <= 1'b0;
      prg_we_q     <= 1'b0;
      spk_we_q     <= 1'b0;
      prg_addr_q   <= '0;
      prg_data_q   <= '0;
      spk_addr_q   <= '0;
      spk_data_q   <= '0;
      byte_count_q <= '0;
      checksum_q   <= '0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      dl_q         <= ioctl_download;
      ovf_q        <= ovf_d;
      prg_we_q     <= prg_we_d;
      spk_we_q     <= spk_we_d;
      prg_addr_q   <= prg_addr_d;
      prg_data_q   <= prg_data_d;
      spk_addr_q   <= spk_addr_d;
      spk_data_q   <= spk_data_d;
      byte_count_q <= byte_count_d;
      checksum_q   <= checksum_d;
      core_reset_q <= core_reset_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  assign prg_we     = prg_we_q;
  assign prg_addr   = prg_addr_q;
  assign prg_data   = prg_data_q;
  assign spk_we     = spk_we_q;
  assign spk_addr   = spk_addr_q;
  assign spk_data   = spk_data_q;
  assign byte_count = byte_count_q;
  assign checksum   = checksum_q;
  assign core_reset = core_reset_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_berzerk_rom_loader.sv
// Directed bench for berzerk_rom_loader: region split, full/short/overflow
// loads, reload from DONE and reset in the middle of a load.
module tb_berzerk_rom_loader;
  import berzerk_pkg::*;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [13:0] prg_addr;
  logic [7:0]  prg_data;
  logic        prg_we;
  logic [11:0] spk_addr;
  logic [7:0]  spk_data;
  logic        spk_we;
  logic        core_reset;
  logic        load_done;
  logic        load_err;
  logic [16:0] byte_count;
  logic [7:0]  checksum;

  int checks = 0;
  int passed = 0;

  always #5 clk_sys = ~clk_sys;

  berzerk_rom_loader dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .prg_addr       (prg_addr),
    .prg_data       (prg_data),
    .prg_we         (prg_we),
    .spk_addr       (spk_addr),
    .spk_data       (spk_data),
    .spk_we         (spk_we),
    .core_reset     (core_reset),
    .load_done      (load_done),
    .load_err       (load_err),
    .byte_count     (byte_count),
    .checksum       (checksum)
  );

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_state(input string tag, input loader_state_t exp);
    chk(tag, 32'(dut.state_q), 32'(exp));
  endtask

  // Raise the download window and confirm the rise-cycle clears.
  task automatic start_dl(input string tag);
    ioctl_download = 1'b1;
    ioctl_wr       = 1'b0;
    tick();
    chk_state({tag, "_state_load"}, LOAD);
    chk({tag, "_rise_core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, "_rise_load_done"}, 32'(load_done), 32'd0);
    chk({tag, "_rise_load_err"}, 32'(load_err), 32'd0);
    chk({tag, "_rise_byte_count"}, 32'(byte_count), 32'd0);
    chk({tag, "_rise_checksum"}, 32'(checksum), 32'd0);
  endtask

  // Bytes 0..n-1 with data = addr[7:0]; the window drops with the last write.
  task automatic feed(input string tag, input int n, input bit extra);
    for (int i = 0; i < n; i++) begin
      ioctl_wr       = 1'b1;
      ioctl_addr     = 25'(i);
      ioctl_dout     = i[7:0];
      ioctl_download = (i == n - 1 && !extra) ? 1'b0 : 1'b1;
      tick();
      chk({tag, "_prg_we"}, 32'(prg_we), 32'(i < 14336));
      chk({tag, "_spk_we"}, 32'(spk_we), 32'(i >= 14336));
    end
    if (extra) begin
      ioctl_wr       = 1'b1;
      ioctl_addr     = 25'h4800;
      ioctl_dout     = 8'h77;
      ioctl_download = 1'b0;
      tick();
      chk({tag, "_ovf_prg_we"}, 32'(prg_we), 32'd0);
      chk({tag, "_ovf_spk_we"}, 32'(spk_we), 32'd0);
    end
    ioctl_wr = 1'b0;
    chk_state({tag, "_state_check"}, CHECK);
  endtask

  initial begin
    reset          = 1'b1;
    ioctl_download = 1'b0;
    ioctl_wr       = 1'b0;
    ioctl_addr     = '0;
    ioctl_dout     = '0;
    tick();
    tick();
    chk_state("rst_state", IDLE);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    chk("rst_we", 32'({prg_we, spk_we}), 32'd0);
    chk("rst_byte_count", 32'(byte_count), 32'd0);
    chk("rst_checksum", 32'(checksum), 32'd0);
    chk("rst_addr", 32'({prg_addr, spk_addr}), 32'd0);
    reset = 1'b0;
    tick();
    chk_state("idle_hold", IDLE);

    // Region split across the prg/spk boundary, back to back.
    start_dl("split");
    ioctl_wr = 1'b1; ioctl_addr = 25'h37FF; ioctl_dout = 8'hA5;
    tick();
    ioctl_addr = 25'h3800; ioctl_dout = 8'h5A;
    chk("split_prg_we", 32'(prg_we), 32'd1);
    chk("split_prg_addr", 32'(prg_addr), 32'h37FF);
    chk("split_prg_data", 32'(prg_data), 32'hA5);
    chk("split_spk_we0", 32'(spk_we), 32'd0);
    tick();
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    chk("split_spk_we", 32'(spk_we), 32'd1);
    chk("split_spk_addr", 32'(spk_addr), 32'h000);
    chk("split_spk_data", 32'(spk_data), 32'h5A);
    chk("split_prg_we0", 32'(prg_we), 32'd0);
    tick();
    chk_state("split_state_check", CHECK);
    tick();
    chk("split_load_err", 32'(load_err), 32'd1);
    chk("split_byte_count", 32'(byte_count), 32'd2);
    chk("split_checksum", 32'(checksum), 32'hFF);

    // Full valid image.
    start_dl("full");
    feed("full", 18432, 1'b0);
    tick();
    chk_state("full_state_done", DONE);
    chk("full_load_done", 32'(load_done), 32'd1);
    chk("full_core_reset", 32'(core_reset), 32'd0);
    chk("full_load_err", 32'(load_err), 32'd0);
    chk("full_byte_count", 32'(byte_count), 32'd18432);
    chk("full_checksum", 32'(checksum), 32'h00);
    tick();
    chk("full_hold_count", 32'(byte_count), 32'd18432);

    // Reload straight from DONE.
    start_dl("reload");
    feed("reload", 18432, 1'b0);
    tick();
    chk("reload_load_done", 32'(load_done), 32'd1);
    chk("reload_core_reset", 32'(core_reset), 32'd0);

    // One byte short.
    start_dl("short");
    feed("short", 18431, 1'b0);
    tick();
    chk("short_load_err", 32'(load_err), 32'd1);
    chk("short_core_reset", 32'(core_reset), 32'd1);
    chk("short_load_done", 32'(load_done), 32'd0);
    chk("short_byte_count", 32'(byte_count), 32'd18431);
    chk("short_checksum", 32'(checksum), 32'h01);

    // Full image plus one write past the end.
    start_dl("ovf");
    feed("ovf", 18432, 1'b1);
    tick();
    chk("ovf_load_err", 32'(load_err), 32'd1);
    chk("ovf_load_done", 32'(load_done), 32'd0);
    chk("ovf_byte_count", 32'(byte_count), 32'd18432);
    chk("ovf_checksum", 32'(checksum), 32'h00);

    // Reset after 100 bytes.
    start_dl("mid");
    for (int i = 0; i < 100; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i); ioctl_dout = 8'h01;
      tick();
    end
    chk("mid_byte_count", 32'(byte_count), 32'd100);
    chk("mid_checksum", 32'(checksum), 32'd100);
    reset = 1'b1; ioctl_download = 1'b0; ioctl_wr = 1'b0;
    tick();
    reset = 1'b0;
    chk_state("mid_state_idle", IDLE);
    chk("mid_rst_count", 32'(byte_count), 32'd0);
    chk("mid_rst_core_reset", 32'(core_reset), 32'd1);
    chk("mid_rst_prg_we", 32'(prg_we), 32'd0);
    for (int i = 0; i < 3; i++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(i * 8000); ioctl_dout = 8'h33;
      tick();
      chk("mid_post_we", 32'({prg_we, spk_we}), 32'd0);
    end
    ioctl_wr = 1'b0;
    tick();
    chk("mid_post_count", 32'(byte_count), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
